// File: rtl/password_rx_if.sv
// password_rx_if: serial line and result signals of the password receiver.
//
// Handshake: byte_valid and frame_err are single-cycle pulses with no ready
// and no backpressure. The consumer must take byte_data in the pulse cycle.
// byte_data keeps its value until the next byte_valid. byte_valid and
// frame_err are never high in the same cycle.
//
// dbg_state and dbg_match expose the receive FSM state and the password
// match index for observation only.
interface password_rx_if;
  logic       rx;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       led_g_n;
  logic       led_r_n;
  logic [1:0] dbg_state;
  logic [2:0] dbg_match;

  modport slave (
    input  rx,
    output byte_valid, byte_data, frame_err, led_g_n, led_r_n,
    output dbg_state, dbg_match
  );

  modport master (
    output rx,
    input  byte_valid, byte_data, frame_err, led_g_n, led_r_n,
    input  dbg_state, dbg_match
  );
endinterface

// File: rtl/password_rx.sv
// password_rx: 8N1 serial receiver followed by a fixed 8-byte password checker
// that drives active-low green (unlocked) and red (locked) LEDs.
//
// Optional feature macro: PW_LOCKOUT_EN. When defined, MAX_FAILS checker
// mismatches or framing errors while locked latch a permanent lockout that
// only reset clears. When undefined, attempts are unlimited.
module password_rx #(
  parameter int          CLK_HZ    = 12000000,
  parameter int          BAUD      = 115200,
  parameter logic [63:0] PASSWORD  = 64'h293a216b33713234,
  parameter int          MAX_FAILS = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  password_rx_if.slave  bus
);

  localparam int         BAUD_P  = CLK_HZ / BAUD;
  localparam logic [6:0] HALF_M1 = 7'(BAUD_P / 2 - 1);
  localparam logic [6:0] FULL_M1 = 7'(BAUD_P - 1);

  // The baud counter is 7 bits wide and the fail counter 2 bits wide.
  if (BAUD_P < 4 || BAUD_P > 128) begin : g_bad_baud
    $error("password_rx: CLK_HZ/BAUD must be in 4..128");
  end
  if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_bad_max_fails
    $error("password_rx: MAX_FAILS must be in 1..3");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Synchroniser and receiver state
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;
  rx_state_e  state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       armed_q, armed_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       frame_err_q, frame_err_d;

  // Checker state
  logic [2:0] m_q, m_d;
  logic       unlocked_q, unlocked_d;
  logic       led_g_n_q, led_g_n_d;
  logic       led_r_n_q, led_r_n_d;

  logic [7:0] pw_byte;
  logic       checker_active;
  logic       byte_match;

  // Receiver: two-flop synchroniser plus IDLE/START/DATA/STOP sequencing.
  always_comb begin
    rx_meta_d    = bus.rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_data_d  = byte_data_q;
    case (state_q)
      ST_IDLE: begin
        // A start edge counts only once the line has been seen high, so a
        // stop bit held low cannot immediately retrigger a frame.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          cnt_d   = 7'd0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = 7'd0;
          idx_d = 3'd0;
          if (!rx_s_q) state_d = ST_DATA;
          else         state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 7'd0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 7'd0;
          state_d = ST_IDLE;
          if (rx_s_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PW_LOCKOUT_EN
  logic [1:0] fails_q, fails_d;
  logic       locked_out_q, locked_out_d;
`endif

  assign pw_byte    = PASSWORD[8*m_q +: 8];
  assign byte_match = (byte_data_q == pw_byte);
`ifdef PW_LOCKOUT_EN
  assign checker_active = !unlocked_q && !locked_out_q;
`else
  assign checker_active = !unlocked_q;
`endif

  // Checker: advance the match index on each received byte while locked.
  always_comb begin
    m_d        = m_q;
    unlocked_d = unlocked_q;
`ifdef PW_LOCKOUT_EN
    fails_d      = fails_q;
    locked_out_d = locked_out_q;
`endif
    if (frame_err_q) begin
      m_d = 3'd0;
`ifdef PW_LOCKOUT_EN
      if (checker_active) fails_d = fails_q + 2'd1;
`endif
    end else if (byte_valid_q && checker_active) begin
      if (byte_match) begin
        m_d = m_q + 3'd1;
        if (m_q == 3'd7) unlocked_d = 1'b1;
      end else begin
        // Password byte 0 occurs nowhere else, so a mismatching byte can
        // only ever restart the match at position 0 or 1.
        m_d = (byte_data_q == PASSWORD[7:0]) ? 3'd1 : 3'd0;
`ifdef PW_LOCKOUT_EN
        fails_d = fails_q + 2'd1;
`endif
      end
    end
`ifdef PW_LOCKOUT_EN
    if (unlocked_d && !unlocked_q) fails_d = 2'd0;
    if (32'(fails_d) >= MAX_FAILS) locked_out_d = 1'b1;
    led_g_n_d = !unlocked_d || locked_out_d;
`else
    led_g_n_d = !unlocked_d;
`endif
    led_r_n_d = !led_g_n_d;
  end

  // State register for receiver, checker and LED outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= 7'd0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      armed_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      frame_err_q  <= 1'b0;
      m_q          <= 3'd0;
      unlocked_q   <= 1'b0;
      led_g_n_q    <= 1'b1;
      led_r_n_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
      m_q          <= m_d;
      unlocked_q   <= unlocked_d;
      led_g_n_q    <= led_g_n_d;
      led_r_n_q    <= led_r_n_d;
    end
  end

`ifdef PW_LOCKOUT_EN
  // Lockout registers, present only when the lockout feature is built.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fails_q      <= 2'd0;
      locked_out_q <= 1'b0;
    end else begin
      fails_q      <= fails_d;
      locked_out_q <= locked_out_d;
    end
  end
`endif

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.led_g_n    = led_g_n_q;
  assign bus.led_r_n    = led_r_n_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_match  = m_q;

endmodule

// File: tb/tb_password_rx.sv
// tb_password_rx: drives 8N1 frames, glitches, bad stop bits and resets into
// password_rx and checks received bytes, pulses and LEDs against a model that
// unlocks once the last eight good bytes since the last framing error spell
// the password.
module tb_password_rx;
  localparam int BAUD_P = 12000000 / 115200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  password_rx_if bus ();

  password_rx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] pw = 64'h293a216b33713234;
  logic [7:0]  exp_q[$];
  logic [7:0]  hist[$];
  logic [7:0]  seq_q[$];
  int          ferr_pending = 0;
  bit          mdl_unlocked = 1'b0;
  logic [7:0]  mdl_last = 8'h00;
  bit          rst_prev = 1'b1;
`ifdef PW_LOCKOUT_EN
  int          mdl_fails = 0;
  bit          mdl_locked_out = 1'b0;
`endif

  // Longest suffix of the accepted byte history that is a password prefix.
  function automatic int match_len();
    int n;
    n = (hist.size() < 8) ? hist.size() : 8;
    for (int k = n; k > 0; k--) begin
      bit ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (hist[hist.size() - k + i] != pw[8*i +: 8]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int old_len;
    if (mdl_unlocked) return;
`ifdef PW_LOCKOUT_EN
    if (mdl_locked_out) return;
`endif
    old_len = match_len();
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    if (match_len() == 8) mdl_unlocked = 1'b1;
`ifdef PW_LOCKOUT_EN
    if (match_len() != old_len + 1) mdl_fails++;
    if (mdl_unlocked) mdl_fails = 0;
    if (mdl_fails >= 3) mdl_locked_out = 1'b1;
`else
    if (old_len < 0) mdl_unlocked = 1'b0;
`endif
  endfunction

  function automatic void model_ferr();
`ifdef PW_LOCKOUT_EN
    if (!mdl_unlocked && !mdl_locked_out) begin
      mdl_fails++;
      if (mdl_fails >= 3) mdl_locked_out = 1'b1;
    end
`endif
    hist.delete();
  endfunction

  function automatic bit led_green();
`ifdef PW_LOCKOUT_EN
    return mdl_unlocked && !mdl_locked_out;
`else
    return mdl_unlocked;
`endif
  endfunction

  // Monitor on the falling edge: check outputs, then advance the model.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_prev) begin
      check("rst_valid", bus.byte_valid, 1'b0);
      check("rst_ferr", bus.frame_err, 1'b0);
      check("rst_data", bus.byte_data, 8'h00);
      check("rst_led_g_n", bus.led_g_n, 1'b1);
      check("rst_led_r_n", bus.led_r_n, 1'b0);
    end else begin
      check("led_g_n", bus.led_g_n, !led_green());
      check("led_r_n", bus.led_r_n, led_green());
      check("valid_ferr_excl", bus.byte_valid & bus.frame_err, 1'b0);
      if (bus.byte_valid) begin
        check("valid_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte_data", bus.byte_data, e);
          mdl_last = e;
          model_byte(e);
        end
      end else begin
        check("data_hold", bus.byte_data, mdl_last);
      end
      if (bus.frame_err) begin
        check("ferr_expected", ferr_pending > 0, 1'b1);
        if (ferr_pending > 0) ferr_pending--;
        model_ferr();
      end
    end
    rst_prev = !reset_n;
    if (!reset_n) begin
      exp_q.delete();
      hist.delete();
      ferr_pending = 0;
      mdl_unlocked = 1'b0;
      mdl_last = 8'h00;
`ifdef PW_LOCKOUT_EN
      mdl_fails = 0;
      mdl_locked_out = 1'b0;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int n);
    @(posedge clk);
    #1 bus.rx = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    hold(1'b0, BAUD_P);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD_P);
    if (good_stop) begin
      exp_q.push_back(b);
      hold(1'b1, BAUD_P);
    end else begin
      ferr_pending++;
      hold(1'b0, BAUD_P);
      hold(1'b1, BAUD_P);
    end
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq_q.size(); i++) send_byte(seq_q[i], 1'b1);
  endtask

  task automatic load_pw();
    seq_q.delete();
    for (int i = 0; i < 8; i++) seq_q.push_back(pw[8*i +: 8]);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.rx = 1'b1;
    hold(1'b1, 20);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    bus.rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    hold(1'b1, 20);

    // Correct password, back to back.
    load_pw();
    send_seq();
    hold(1'b1, 200);
    check("pw_unlock_g", bus.led_g_n, 1'b0 ^ !led_green());
    check("pw_unlock_r", bus.led_r_n, led_green());

    // Partial then wrong, then the full password.
    pulse_reset();
    seq_q = '{8'h34, 8'h32, 8'h00};
    send_seq();
    hold(1'b1, 100);
    check("partial_locked", bus.led_g_n, 1'b1);
    load_pw();
    send_seq();
    hold(1'b1, 100);
    check("after_partial_unlock", bus.led_g_n, !led_green());

    // Overlapping restart on a repeated first byte.
    pulse_reset();
    seq_q = '{8'h34};
    send_seq();
    load_pw();
    send_seq();
    hold(1'b1, 100);
    check("overlap_unlock", bus.led_g_n, !led_green());

    // Short low glitch: nothing received.
    pulse_reset();
    hold(1'b0, 30);
    hold(1'b1, 200);
    check("glitch_idle", bus.dbg_state, 2'd0);

    // Bad stop bit after a partial match clears the match index.
    seq_q = '{8'h34, 8'h32};
    send_seq();
    send_byte(8'h71, 1'b0);
    hold(1'b1, 200);
    check("ferr_match_clear", bus.dbg_match, 3'd0);
    send_byte(8'h34, 1'b1);
    hold(1'b1, 100);

    // Reset during data bit 4, then a fresh frame.
    b = 8'h71;
    hold(1'b0, BAUD_P);
    for (int i = 0; i < 4; i++) hold(b[i], BAUD_P);
    hold(b[4], 50);
    pulse_reset();
    hold(1'b1, 12 * BAUD_P);
    send_byte(8'h34, 1'b1);
    hold(1'b1, 100);

`ifdef PW_LOCKOUT_EN
    // Three failures lock the checker out for good.
    pulse_reset();
    seq_q = '{8'h00, 8'h11, 8'h22};
    send_seq();
    load_pw();
    send_seq();
    hold(1'b1, 100);
    check("lockout_g", bus.led_g_n, 1'b1);
    check("lockout_r", bus.led_r_n, 1'b0);
`endif

    // Randomized mix of bytes, password runs, glitches and framing errors.
    pulse_reset();
    for (int n = 0; n < 25; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        hold(1'b0, $urandom_range(1, 45));
        hold(1'b1, 80);
      end else if (kind == 1) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
      end else if (kind == 2) begin
        load_pw();
        send_seq();
      end else if (kind < 6) begin
        send_byte(pw[8*$urandom_range(0, 7) +: 8], 1'b1);
      end else begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end
      if ($urandom_range(0, 2) != 0) hold(1'b1, $urandom_range(1, 200));
    end

    hold(1'b1, 300);
    check("exp_q_empty", exp_q.size(), 0);
    check("ferr_pending", ferr_pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
